// File: rtl/ahb_apb_bridge_p_pkg.sv
// Shared encodings and FSM state type for the parametrised AHB-Lite to APB bridge.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Slave-index field width; a single slave still needs one bit.
    function automatic int idx_width(input int nslv);
        return (nslv <= 1) ? 1 : $clog2(nslv);
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_p_if.sv
// AHB-Lite slave side and APB master side of the bridge, bundled as one interface.
interface ahb_apb_bridge_p_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
);
    logic              hreadyin;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic              hreadyout;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;
    logic [NSLV-1:0]   psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    // The bridge itself
    modport slave (
        input  hreadyin, htrans, hwrite, haddr, hwdata, prdata, pready, pslverr,
        output hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
    );

    // AHB master plus APB slaves surrounding the bridge
    modport master (
        output hreadyin, htrans, hwrite, haddr, hwdata, prdata, pready, pslverr,
        input  hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/ahb_apb_decode.sv
// Combinational address decoder: bridge window match plus slave index range check.
module ahb_apb_decode
    import ahb_apb_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              NSLV      = 3,
    parameter int              SLV_SHIFT = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int              IDX_W     = idx_width(NSLV)
) (
    input  logic [ADDR_W-1:SLV_SHIFT] haddr_hi,
    output logic                      hit,
    output logic [IDX_W-1:0]          idx
);
    localparam int TOP_LSB = SLV_SHIFT + IDX_W;

    logic upper_ok;
    logic idx_ok;

    assign idx = haddr_hi[SLV_SHIFT +: IDX_W];

    generate
        if (TOP_LSB < ADDR_W) begin : g_upper
            assign upper_ok = (haddr_hi[ADDR_W-1:TOP_LSB] == BASE_ADDR[ADDR_W-1:TOP_LSB]);
        end else begin : g_no_upper
            assign upper_ok = 1'b1;
        end

        // A power-of-two slave count leaves no unused index codes.
        if (NSLV == (1 << IDX_W)) begin : g_full_idx
            assign idx_ok = 1'b1;
        end else begin : g_part_idx
            assign idx_ok = ({1'b0, idx} < (IDX_W + 1)'(NSLV));
        end
    endgenerate

    assign hit = upper_ok & idx_ok;

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// AHB-Lite slave to APB master bridge with wait states, slave/decode errors and access timeout.
module ahb_apb_bridge_p
    import ahb_apb_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              NSLV      = 3,
    parameter int              SLV_SHIFT = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int              TIMEOUT   = 16
) (
    input logic               hclk,
    input logic               hreset,
    ahb_apb_bridge_p_if.slave bus
);
    localparam int  IDX_W = idx_width(NSLV);
    localparam int  CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit  TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_q, state_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic              hreadyout_q, hreadyout_d;
    logic [1:0]        hresp_q, hresp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              accept;
    logic [NSLV-1:0]   sel_onehot;

    ahb_apb_decode #(
        .ADDR_W   (ADDR_W),
        .NSLV     (NSLV),
        .SLV_SHIFT(SLV_SHIFT),
        .BASE_ADDR(BASE_ADDR),
        .IDX_W    (IDX_W)
    ) u_decode (
        .haddr_hi(bus.haddr[ADDR_W-1:SLV_SHIFT]),
        .hit     (dec_hit),
        .idx     (dec_idx)
    );

    assign accept = bus.hreadyin &&
                    ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));

    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_sel
            assign sel_onehot[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            cnt_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
        end
    end

    // Every output is registered, so each branch sets the values the next state presents.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hrdata_d    = hrdata_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;

        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d     = ST_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                if (accept) begin
                    hreadyout_d = 1'b0;
                    if (dec_hit) begin
                        state_d  = ST_LATCH;
                        paddr_d  = bus.haddr;
                        pwrite_d = bus.hwrite;
                        idx_d    = dec_idx;
                    end else begin
                        state_d = ST_ERR1;
                        hresp_d = HRESP_ERROR;
                    end
                end
            end
            ST_LATCH: begin
                if (pwrite_q) begin
                    pwdata_d = bus.hwdata;
                end
                psel_d  = sel_onehot;
                cnt_d   = '0;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (bus.pslverr) begin
                        state_d = ST_ERR1;
                        hresp_d = HRESP_ERROR;
                    end else begin
                        state_d     = ST_IDLE;
                        hreadyout_d = 1'b1;
                        if (!pwrite_q) begin
                            hrdata_d = bus.prdata;
                        end
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_ERR1;
                    hresp_d   = HRESP_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR1: begin
                state_d     = ST_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.hrdata    = hrdata_q;
    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;

endmodule

// File: doc/ahb_apb_bridge_p.md
Name: ahb_apb_bridge_p

Overview:
Parametrised AHB-Lite-slave to APB-master bridge. It replaces the fixed 3-slave bridge in the AHB/APB subsystem. Width, slave count and address map are set by parameters. Adds PREADY wait states, PSLVERR and decode-error reporting as a two-cycle AHB ERROR response, and an APB access timeout.

Parameters:
ADDR_W, 32, address width (haddr/paddr)
DATA_W, 32, data width (hwdata/hrdata/pwdata/prdata)
NSLV, 3, number of APB slaves (1..16); IDX_W = max(1, clog2(NSLV)) is a localparam
SLV_SHIFT, 12, LSB of slave-index field in haddr (4 KB per slave)
BASE_ADDR, 32'h8000_0000, bridge base; haddr[ADDR_W-1:SLV_SHIFT+IDX_W] must equal the same bits of BASE_ADDR
TIMEOUT, 16, max ACCESS cycles without pready before error; 0 disables

Ports:
hclk  in  1  clock, rising edge
hreset  in  1  asynchronous reset, active-high
hreadyin  in  1  AHB HREADY (bus)
htrans  in  2  AHB transfer type
hwrite  in  1  AHB direction
haddr  in  ADDR_W  AHB address
hwdata  in  DATA_W  AHB write data (data phase)
hreadyout  out  1  AHB ready out
hresp  out  2  00 OKAY, 01 ERROR
hrdata  out  DATA_W  AHB read data
psel  out  NSLV  one-hot APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data (externally muxed)
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- All outputs registered. Reset (async, any state): state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, hreadyout=1, hresp=00, timeout count 0.
- Accept: in IDLE or ERR2, at a rising edge with hreadyin=1 and htrans[1]=1 (NONSEQ/SEQ). Latch haddr, hwrite and decoded index. IDLE/BUSY htrans are ignored, as is any cycle with hreadyin=0.
- Decode: hit when the upper bits match BASE_ADDR and idx=haddr[SLV_SHIFT+:IDX_W] < NSLV. Miss -> ERR1, with no APB activity.
- FSM:
  - IDLE: hreadyout=1, hresp=00.
  - LATCH (one cycle, reads too): hreadyout=0; capture hwdata into pwdata when writing.
  - SETUP: psel[idx]=1, penable=0, paddr/pwrite valid.
  - ACCESS: penable=1.
    - pready=1, pslverr=0 -> IDLE with hreadyout=1. On a read, hrdata<=prdata in that same edge.
    - pready=1, pslverr=1 -> ERR1.
    - pready=0 -> stay; increment the counter.
    - Counter reaches TIMEOUT (TIMEOUT≠0) -> ERR1.
  - Leaving ACCESS clears psel and penable.
  - ERR1: hreadyout=0, hresp=01.
  - ERR2: hreadyout=1, hresp=01. Next edge -> IDLE, or LATCH if a new transfer is accepted.
- hrdata changes only on a successful read; it holds otherwise.
- Latency with pready tied to 1: address edge T0; hreadyout low T1–T3; hreadyout high with data at T4, i.e. 3 wait states. Each pready=0 cycle adds one.
- paddr/pwrite/pwdata stay stable from SETUP through ACCESS completion. psel is never multi-hot.
- Timeout counter: width clog2(TIMEOUT+1); cleared on entering SETUP.
- Reset asserted mid-ACCESS: psel/penable drop immediately and no error response is issued.

Decomposition:
- Package ahb_apb_pkg holds:
  - htrans encodings (IDLE/BUSY/NONSEQ/SEQ)
  - hresp encodings (OKAY/ERROR)
  - FSM state enum (IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2)
- One sub-module, ahb_apb_decode: combinational haddr -> {hit, idx}, parametrised like the top. The FSM and datapath stay in the top.

Test Plan:
- Write to 0x8000_1004, hwdata 0xDEAD_BEEF, pready=1 -> psel=3'b010 SETUP T2, penable T3, paddr 0x8000_1004, pwdata 0xDEAD_BEEF; hreadyout high T4, hresp=00.
- Read 0x8000_2008, prdata 0x1234_5678, pready low 2 ACCESS cycles -> hreadyout low T1–T5, hrdata=0x1234_5678 at T6.
- Read 0x8000_3000 (NSLV=3) -> no psel, ERR1 hreadyout=0/hresp=01, then ERR2 hreadyout=1/hresp=01; also 0x9000_0000 -> same.
- Write to slave 0 with pslverr=1 on completion -> two-cycle ERROR; pwdata unchanged, hrdata unchanged.
- TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then ERROR response and psel cleared.
- Back-to-back NONSEQ reads with next address held through the wait states -> second accepted at the T4 edge, second LATCH at T5; hreset pulse mid-ACCESS -> all outputs at reset values within the same cycle.
